velocity_cell_reader: RTL



---
 rtl/velocity_cell_reader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/velocity_cell_reader.sv
// Streams one cell's particle velocities out of a 1-cycle-latency RAM.
// Optional abort input enabled by defining VEL_READER_ABORT_EN.
module velocity_cell_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef VEL_READER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_REQ,
        S_CNT_WAIT,
        S_STREAM,
        S_FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;
    logic                  infl_q, infl_d;
    logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [ADDR_WIDTH-1:0] i0_q, i0_d, i1_q, i1_d;

    logic       abort_hit;
    logic       hs;
    logic       push;
    logic       more;
    logic       room;
    logic       issue;
    logic [2:0] pending;

`ifdef VEL_READER_ABORT_EN
    assign abort_hit = abort && (state_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign out_valid = (state_q == S_STREAM) && (occ_q != 2'd0);
    assign hs        = out_valid && out_ready;
    assign push      = infl_q && !abort_hit;
    assign more      = addr_q <= {1'b0, count_q};

    // Slots already claimed once this cycle's handshake retires the head.
    assign pending = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, hs};
    assign room    = pending < 3'd2;
    assign issue   = (state_q == S_STREAM) && more && room && !abort_hit;

    assign mem_rden    = (state_q == S_CNT_REQ) || issue;
    assign mem_address = issue ? addr_q[ADDR_WIDTH-1:0] : '0;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;

    assign out_data  = d0_q;
    assign out_index = i0_q;
    assign out_last  = out_valid && (i0_q == count_q);
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_FINISH;
    assign count_err = err_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        err_d      = err_q;
        addr_d     = addr_q;
        infl_d     = 1'b0;
        infl_idx_d = infl_idx_q;
        occ_d      = occ_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        i0_d       = i0_q;
        i1_d       = i1_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CNT_REQ;
                    err_d   = 1'b0;
                end
            end
            S_CNT_REQ: state_d = S_CNT_WAIT;
            S_CNT_WAIT: begin
                if (mem_q[ADDR_WIDTH-1:0] > MAX_CNT) begin
                    count_d = MAX_CNT;
                    err_d   = 1'b1;
                end else begin
                    count_d = mem_q[ADDR_WIDTH-1:0];
                end
                addr_d  = (ADDR_WIDTH+1)'(1);
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (count_q == '0) begin
                    state_d = S_FINISH;
                end else if (hs && out_last) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (issue) begin
            infl_d     = 1'b1;
            infl_idx_d = addr_q[ADDR_WIDTH-1:0];
            addr_d     = addr_q + 1'b1;
        end

        case (occ_q)
            2'd0: begin
                if (push) begin
                    d0_d  = mem_q;
                    i0_d  = infl_idx_q;
                    occ_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && hs) begin
                    d0_d = mem_q;
                    i0_d = infl_idx_q;
                end else if (push) begin
                    d1_d  = mem_q;
                    i1_d  = infl_idx_q;
                    occ_d = 2'd2;
                end else if (hs) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (hs) begin
                    d0_d = d1_q;
                    i0_d = i1_q;
                    if (push) begin
                        d1_d = mem_q;
                        i1_d = infl_idx_q;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
            default: occ_d = 2'd0;
        endcase

        if (abort_hit) begin
            state_d = S_IDLE;
            occ_d   = 2'd0;
            infl_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            infl_q     <= 1'b0;
            infl_idx_q <= '0;
            occ_q      <= 2'd0;
            d0_q       <= '0;
            d1_q       <= '0;
            i0_q       <= '0;
            i1_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            infl_q     <= infl_d;
            infl_idx_q <= infl_idx_d;
            occ_q      <= occ_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            i0_q       <= i0_d;
            i1_q       <= i1_d;
        end
    end

endmodule
